// File: rtl/serial_slave_port.sv
// serial_slave_port
// Bus slave endpoint: decodes a serial control frame (START, ID, R/W, burst
// flag, address, optional LEN) and then moves one or LEN+1 words between a
// small register memory and the serial wrD/rD lines under valid/ready
// bit-level handshaking. Memory contents are not reset.

module serial_slave_port #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int SLAVE_ID_WIDTH = 3,
  parameter int SLAVE_ID       = 1,
  parameter int BURST_WIDTH    = 4
) (
  input  logic clk,
  input  logic rstN,
  input  logic control,
  input  logic wrD,
  input  logic valid,
  output logic rD,
  output logic ready
);

  localparam int DEPTH     = 1 << ADDR_WIDTH;
  // Frame bits after START without / with the LEN field.
  localparam int HDR_BITS  = SLAVE_ID_WIDTH + 2 + ADDR_WIDTH;
  localparam int FRAME_MAX = HDR_BITS + BURST_WIDTH;
  localparam int CNT_MAX   = (FRAME_MAX > DATA_WIDTH) ? FRAME_MAX : DATA_WIDTH;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  // Bit-counter positions of the frame fields (0 = first ID bit).
  localparam logic [CNT_W-1:0] POS_RW      = CNT_W'(SLAVE_ID_WIDTH);
  localparam logic [CNT_W-1:0] POS_B       = CNT_W'(SLAVE_ID_WIDTH + 1);
  localparam logic [CNT_W-1:0] POS_LEN     = CNT_W'(HDR_BITS);
  localparam logic [CNT_W-1:0] LAST_HDR    = CNT_W'(HDR_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_BURST  = CNT_W'(FRAME_MAX - 1);
  localparam logic [CNT_W-1:0] LAST_DATA   = CNT_W'(DATA_WIDTH - 1);

  localparam logic [CNT_W-1:0]          CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]          CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0]     ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [BURST_WIDTH-1:0]    WCNT_ZERO = {BURST_WIDTH{1'b0}};
  localparam logic [BURST_WIDTH-1:0]    WCNT_ONE  = {{(BURST_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [SLAVE_ID_WIDTH-1:0] MY_ID     = SLAVE_ID_WIDTH'(SLAVE_ID);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CTRL   = 3'd1,
    ST_WRITE  = 3'd2,
    ST_RLOAD  = 3'd3,
    ST_RSHIFT = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  state_e                    state_q;
  logic [CNT_W-1:0]          bit_cnt_q;
  logic [SLAVE_ID_WIDTH-1:0] id_q;
  logic                      wr_q;
  logic                      burst_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  // Words still to transfer after the current one; LEN shifts straight in.
  logic [BURST_WIDTH-1:0]    wcnt_q;
  logic [DATA_WIDTH-1:0]     shift_q;
  logic                      ready_q;

  logic [DATA_WIDTH-1:0]     mem_q [DEPTH];

  logic                      frame_last;
  logic                      id_hit;
  logic                      data_last;
  logic                      mem_we;
  logic [DATA_WIDTH-1:0]     mem_wdata;

  // Decode of frame end, ID match, word end and the memory write strobe.
  always_comb begin
    frame_last = 1'b0;
    id_hit     = (id_q == MY_ID);
    data_last  = (bit_cnt_q == LAST_DATA);
    mem_wdata  = {shift_q[DATA_WIDTH-2:0], wrD};
    mem_we     = 1'b0;
    // B is captured well before the last header bit, so it selects the end.
    if (burst_q) begin
      frame_last = (bit_cnt_q == LAST_BURST);
    end else begin
      frame_last = (bit_cnt_q == LAST_HDR);
    end
    if ((state_q == ST_WRITE) && valid && data_last) begin
      mem_we = 1'b1;
    end else begin
      mem_we = 1'b0;
    end
  end

  // Register memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[addr_q] <= mem_wdata;
    end
  end

  // Control FSM with frame decode, datapath and registered ready.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= CNT_ZERO;
      id_q      <= {SLAVE_ID_WIDTH{1'b0}};
      wr_q      <= 1'b0;
      burst_q   <= 1'b0;
      addr_q    <= {ADDR_WIDTH{1'b0}};
      wcnt_q    <= WCNT_ZERO;
      shift_q   <= {DATA_WIDTH{1'b0}};
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b0;
          if (control) begin
            state_q   <= ST_CTRL;
            bit_cnt_q <= CNT_ZERO;
            burst_q   <= 1'b0;
            wcnt_q    <= WCNT_ZERO;
          end
        end

        ST_CTRL: begin
          bit_cnt_q <= bit_cnt_q + CNT_ONE;
          if (bit_cnt_q < POS_RW) begin
            id_q <= {id_q[SLAVE_ID_WIDTH-2:0], control};
          end else if (bit_cnt_q == POS_RW) begin
            wr_q <= control;
          end else if (bit_cnt_q == POS_B) begin
            burst_q <= control;
          end else if (bit_cnt_q < POS_LEN) begin
            addr_q <= {addr_q[ADDR_WIDTH-2:0], control};
          end else begin
            wcnt_q <= {wcnt_q[BURST_WIDTH-2:0], control};
          end

          // Whole frame is consumed even on a miss so no frame bit is a START.
          if (frame_last) begin
            bit_cnt_q <= CNT_ZERO;
            if (!id_hit) begin
              state_q <= ST_IDLE;
              ready_q <= 1'b0;
            end else if (wr_q) begin
              state_q <= ST_WRITE;
              ready_q <= 1'b1;
            end else begin
              state_q <= ST_RLOAD;
              ready_q <= 1'b0;
            end
          end
        end

        ST_WRITE: begin
          if (valid) begin
            shift_q <= mem_wdata;
            if (data_last) begin
              addr_q    <= addr_q + ADDR_ONE;
              bit_cnt_q <= CNT_ZERO;
              if (wcnt_q == WCNT_ZERO) begin
                state_q <= ST_DONE;
                ready_q <= 1'b0;
              end else begin
                wcnt_q <= wcnt_q - WCNT_ONE;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_ONE;
            end
          end
        end

        ST_RLOAD: begin
          shift_q   <= mem_q[addr_q];
          bit_cnt_q <= CNT_ZERO;
          state_q   <= ST_RSHIFT;
          ready_q   <= 1'b1;
        end

        ST_RSHIFT: begin
          if (valid) begin
            shift_q <= {shift_q[DATA_WIDTH-2:0], 1'b0};
            if (data_last) begin
              addr_q    <= addr_q + ADDR_ONE;
              bit_cnt_q <= CNT_ZERO;
              ready_q   <= 1'b0;
              if (wcnt_q == WCNT_ZERO) begin
                state_q <= ST_DONE;
              end else begin
                wcnt_q  <= wcnt_q - WCNT_ONE;
                state_q <= ST_RLOAD;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_ONE;
            end
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
        end

        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_q;
  // Read data is the shift register MSB: a pure register output.
  assign rD    = shift_q[DATA_WIDTH-1];

endmodule

// File: doc/serial_slave_port.md
# serial_slave_port

Serial-bus slave endpoint that sits directly downstream of the bus master. It decodes the master's serial control frame on `control`, then accepts write data serially on `wrD` or returns read data serially on `rD`, with `valid`/`ready` bit-level handshaking. Single-word and fixed-length burst transfers are supported. Data is stored in a small internal register memory.

## Interface
- `DATA_WIDTH`, 8, bits per data word.
- `ADDR_WIDTH`, 4, address bits; memory depth is 2^ADDR_WIDTH words.
- `SLAVE_ID_WIDTH`, 3, width of the slave ID field.
- `SLAVE_ID`, 1, ID this instance answers to.
- `BURST_WIDTH`, 4, width of the burst LEN field.

- `clk`  in  1  clock; all logic is on the rising edge.
- `rstN`  in  1  asynchronous active-low reset.
- `control`  in  1  serial control frame from the master; idles low.
- `wrD`  in  1  serial write data, MSB first.
- `valid`  in  1  master qualifier: write bit present, or read bit taken.
- `rD`  out  1  serial read data, MSB first.
- `ready`  out  1  slave is in a data phase (accepting or presenting bits).

## Operation
- **Frame format**, sampled one bit per cycle: START(1) | ID (MSB first) | R/W (1 = write) | B (1 = burst) | address (MSB first) | LEN (BURST_WIDTH bits, present only when B = 1).
- **Burst length:** LEN + 1 words. A single transfer is 1 word.
- **IDLE:** `control` = 1 moves to CTRL and clears the bit counter.
- **CTRL:** shifts in SLAVE_ID_WIDTH + 2 + ADDR_WIDTH bits, plus BURST_WIDTH more if B = 1. B is known before the LEN bits arrive. On the last bit:
  - ID mismatch goes to IDLE. The whole frame is consumed so that frame bits are never taken as a new START.
  - Write goes to WRITE.
  - Read goes to RLOAD.
- **WRITE** (`ready` = 1): on each edge with `valid` = 1, shift `wrD` into the shift register and increment the bit counter. `valid` = 0 holds state.
  - On the DATA_WIDTH-th bit: write mem[addr], increment addr modulo depth, decrement the word count.
  - If the count is exhausted, go to DONE; otherwise clear the bit counter and stay in WRITE.
- **RLOAD** (`ready` = 0, one cycle): shift register <= mem[addr]; go to RSHIFT.
- **RSHIFT** (`ready` = 1): `rD` = shift register MSB. On each edge with `valid` = 1, shift left and increment the bit counter.
  - After DATA_WIDTH bits: increment addr modulo depth, decrement the word count.
  - If words remain, go to RLOAD; otherwise go to DONE.
- **DONE** (`ready` = 0, one cycle): go to IDLE. `control` is ignored here.
- `control` is ignored in every state except IDLE. A transfer is never aborted except by reset.
- `wrD` is ignored outside WRITE. `valid` is ignored outside WRITE and RSHIFT.
- Memory is not reset; its contents are undefined until written.

## Timing
- **Reset values:** `ready` = 0, `rD` = 0, state = IDLE, counters and address = 0, shift register = 0.
- **Reset mid-operation** returns to IDLE within the reset assertion. Memory writes already committed persist.
- `ready` is a registered state decode. `rD` comes directly from a register bit; it is never a combinational path from inputs.
- **Single write:** START is sampled at edge 0 and the last frame bit at edge 9 (defaults). `ready` = 1 from edge 9. The word is committed on the edge that samples its last bit, and `ready` = 0 after that same edge.
- **Read:** last frame bit at edge E, RLOAD in cycle E..E+1, `ready` = 1 and `rD` = data MSB from edge E+1. Each word boundary inside a burst inserts one `ready` = 0 RLOAD cycle.
- **Minimum transfer time:**
  - Write: frame + DATA_WIDTH·words + 1 (DONE) cycles.
  - Read adds one RLOAD cycle per word.
- **Address wrap:** addr 2^ADDR_WIDTH − 1 increments to 0.
- A new frame can begin on the first IDLE cycle after DONE.

## Test plan
- **Single write then read:** ID = 1, write, B = 0, addr 5, data 0xA5 with `valid` held high. Then a read of addr 5 → `ready` high for 8 cycles, `rD` = 1,0,1,0,0,1,0,1, then `ready` low and return to IDLE.
- **Burst write with wrap:** addr 14, LEN = 3, words 0x11/0x22/0x33/0x44. Then single reads of addrs 14, 15, 0, 1 → 0x11, 0x22, 0x33, 0x44.
- **Burst read:** addr 14, LEN = 3 → `ready` drops for exactly 1 cycle between words; `rD` streams 0x11, 0x22, 0x33, 0x44.
- **ID mismatch:** frame with ID = 2 for a write to addr 5 with 0xFF → `ready` stays 0 throughout, and a later read of addr 5 still returns 0xA5.
- **Stalls:** `valid` low for 3 cycles after bit 3 of a write word and mid-read → bits held and no data corruption. `control` pulsed high during WRITE → ignored.
- **Reset mid-read:** `rstN` low during RSHIFT → `ready` = 0 and `rD` = 0 immediately. After release, a fresh read of addr 5 returns 0xA5.
